// File: rtl/instr_decode_buffer.sv
// instr_decode_buffer: FIFO of fetched {pc, instr} pairs, decoded at enqueue into RV32I fields,
// raw immediate slices and the extension-select code, with synchronous flush on redirect.
// Ports: clk, rstn (async active-low); flush; in_valid/in_ready/in_pc/in_instr (fetch side);
// out_valid/out_ready/out_pc/out_* fields/immType*/extOp/illegal (decode side).
// Optional: define DECBUF_BYPASS_EN for a zero-latency path from fetch to outputs when empty.
module instr_decode_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [6:0]  out_funct7,
    output logic [11:0] immTypeI,
    output logic [11:0] immTypeS,
    output logic [12:0] immTypeB,
    output logic [19:0] immTypeU,
    output logic [19:0] immTypeJ,
    output logic [2:0]  extOp,
    output logic        illegal
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    // entry layout: {pc[67:36], instr[35:4], ext_op[3:1], illegal[0]}
    localparam int EW = 68;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    dec_ext;
    logic          dec_ill;
    logic [EW-1:0] in_entry, head;
    logic [31:0]   h_instr;
    logic          empty, full, bypass, push, pop;

    always_comb begin
        dec_ext = 3'd0;
        dec_ill = 1'b0;
        case (in_instr[6:0])
            7'b0110011, 7'b0001111, 7'b1110011: dec_ext = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111: dec_ext = 3'd1;
            7'b0100011:                         dec_ext = 3'd2;
            7'b1100011:                         dec_ext = 3'd3;
            7'b0110111, 7'b0010111:             dec_ext = 3'd4;
            7'b1101111:                         dec_ext = 3'd5;
            default:                            dec_ill = 1'b1;
        endcase
    end

    assign in_entry = {in_pc, in_instr, dec_ext, dec_ill};
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;

`ifdef DECBUF_BYPASS_EN
    // empty buffer with a ready consumer: hand the fetched instruction straight through
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = !empty && out_ready && !flush;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d = flush ? '0 : push ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // empty buffer presents all-zero data
    assign head      = bypass ? in_entry : empty ? '0 : mem_q[rd_ptr_q];
    assign h_instr   = head[35:4];
    assign out_valid = !empty || bypass;
    assign out_pc    = head[67:36];
    assign extOp     = head[3:1];
    assign illegal   = head[0];
    assign out_opcode = h_instr[6:0];
    assign out_rd     = h_instr[11:7];
    assign out_funct3 = h_instr[14:12];
    assign out_rs1    = h_instr[19:15];
    assign out_rs2    = h_instr[24:20];
    assign out_funct7 = h_instr[31:25];
    assign immTypeI   = h_instr[31:20];
    assign immTypeS   = {h_instr[31:25], h_instr[11:7]};
    assign immTypeB   = {h_instr[31], h_instr[7], h_instr[30:25], h_instr[11:8], 1'b0};
    assign immTypeU   = h_instr[31:12];
    assign immTypeJ   = {h_instr[31], h_instr[19:12], h_instr[20], h_instr[30:21]};
endmodule

// File: tb/tb_instr_decode_buffer.sv
// tb_instr_decode_buffer: directed checks of the default (DEPTH=2, no bypass) decode buffer.
module tb_instr_decode_buffer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [11:0] immTypeI;
    logic [11:0] immTypeS;
    logic [12:0] immTypeB;
    logic [19:0] immTypeU;
    logic [19:0] immTypeJ;
    logic [2:0]  extOp;
    logic        illegal;
    int n_assert = 0;
    int n_fail = 0;

    instr_decode_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .immTypeI(immTypeI), .immTypeS(immTypeS), .immTypeB(immTypeB),
        .immTypeU(immTypeU), .immTypeJ(immTypeJ), .extOp(extOp), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_extop", 32'(extOp), 0);
        chk("rst_immi", 32'(immTypeI), 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_empty", 32'(out_valid), 0);

        put(32'h100, 32'hFFF00093);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_extop", 32'(extOp), 1);
        chk("addi_immi", 32'(immTypeI), 32'hFFF);
        chk("addi_rd", 32'(out_rd), 1);
        chk("addi_rs1", 32'(out_rs1), 0);
        chk("addi_illegal", 32'(illegal), 0);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_opcode", 32'(out_opcode), 32'h13);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("addi_pop_empty", 32'(out_valid), 0);
        chk("empty_pc_zero", out_pc, 0);
        chk("empty_immi_zero", 32'(immTypeI), 0);

        put(32'h104, 32'h0021A423);
        tick();
        put(32'h108, 32'hFE000EE3);
        tick();
        in_valid = 1'b0;
        chk("sw_full", 32'(in_ready), 0);
        chk("sw_extop", 32'(extOp), 2);
        chk("sw_imms", 32'(immTypeS), 32'h008);
        chk("sw_rs1", 32'(out_rs1), 3);
        chk("sw_rs2", 32'(out_rs2), 2);
        chk("sw_funct3", 32'(out_funct3), 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("beq_pc", out_pc, 32'h108);
        chk("beq_extop", 32'(extOp), 3);
        chk("beq_immb", 32'(immTypeB), 32'h1FFC);
        chk("beq_funct7", 32'(out_funct7), 32'h7F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("beq_pop_empty", 32'(out_valid), 0);

        put(32'h200, 32'h123450B7);
        tick();
        put(32'h204, 32'h008000EF);
        tick();
        in_valid = 1'b0;
        chk("lui_extop", 32'(extOp), 4);
        chk("lui_immu", 32'(immTypeU), 32'h12345);
        chk("lui_rd", 32'(out_rd), 1);
        out_ready = 1'b1;
        tick();
        chk("jal_extop", 32'(extOp), 5);
        chk("jal_immj", 32'(immTypeJ), 32'h00004);
        chk("jal_in_ready", 32'(in_ready), 1);
        put(32'h208, 32'h0000007F);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bad_pc", out_pc, 32'h208);
        chk("bad_illegal", 32'(illegal), 1);
        chk("bad_extop", 32'(extOp), 0);
        chk("bad_opcode", 32'(out_opcode), 32'h7F);
        chk("bad_count_one", 32'(in_ready), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bad_pop_empty", 32'(out_valid), 0);

        put(32'hA0, 32'h00000013);
        tick();
        chk("ord_a_ready", 32'(in_ready), 1);
        put(32'hB0, 32'h00000013);
        tick();
        chk("ord_b_full", 32'(in_ready), 0);
        put(32'hC0, 32'h00000013);
        tick();
        chk("ord_c_held", 32'(in_ready), 0);
        chk("ord_head_a", out_pc, 32'hA0);
        out_ready = 1'b1;
        tick();
        chk("ord_head_b", out_pc, 32'hB0);
        chk("ord_after_pop_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("ord_head_c", out_pc, 32'hC0);
        chk("ord_pushpop_count", 32'(in_ready), 1);
        chk("ord_pushpop_valid", 32'(out_valid), 1);
        tick();
        out_ready = 1'b0;
        chk("ord_drained", 32'(out_valid), 0);

        put(32'h300, 32'hFFF00093);
        tick();
        put(32'h304, 32'hFFF00093);
        tick();
        in_valid = 1'b0;
        chk("mid_rst_pre", 32'(immTypeI), 32'hFFF);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        chk("mid_rst_extop", 32'(extOp), 0);
        chk("mid_rst_immi", 32'(immTypeI), 0);
        rstn = 1'b1;
        tick();
        chk("mid_rst_after", 32'(out_valid), 0);

        put(32'h400, 32'h00000013);
        tick();
        put(32'h404, 32'h00000013);
        tick();
        put(32'h408, 32'h008000EF);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ready", 32'(in_ready), 1);
        chk("flush_pc", out_pc, 0);
        tick();
        chk("flush_dropped", 32'(out_valid), 0);
        put(32'h500, 32'h00000013);
        tick();
        in_valid = 1'b0;
        chk("post_flush_pc", out_pc, 32'h500);
        chk("post_flush_valid", 32'(out_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_decode_buffer.md
Name: instr_decode_buffer

Overview:
- Instruction buffer and field-slicing stage between instruction fetch and the immediate extension / register-read stage.
- Queues fetched {pc, instr} pairs in a small FIFO with a valid/ready handshake.
- Decodes each instruction at enqueue: register indices, opcode/funct fields, raw immediate slices and the 3-bit extension-select code.
- Supports pipeline flush on redirect.

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4; pointers wrap modulo DEPTH.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear (branch/jump redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  buffer accepts; equals !full
- in_pc  input  32  instruction address
- in_instr  input  32  instruction word
- out_valid  output  1  head entry valid; equals !empty
- out_ready  input  1  consumer takes head
- out_pc  output  32  head pc
- out_opcode  output  7  instr[6:0]
- out_rd  output  5  instr[11:7]
- out_funct3  output  3  instr[14:12]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_funct7  output  7  instr[31:25]
- immTypeI  output  12  instr[31:20]
- immTypeS  output  12  {instr[31:25], instr[11:7]}
- immTypeB  output  13  {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
- immTypeU  output  20  instr[31:12]
- immTypeJ  output  20  {instr[31], instr[19:12], instr[20], instr[30:21]} = offset[20:1]; branch unit applies the <<1
- extOp  output  3  extension select
- illegal  output  1  opcode not in RV32I base set

Behaviour:
- extOp encoding by opcode:
  - 0: R-type (0110011), FENCE, SYSTEM
  - 1: OP-IMM (0010011), LOAD (0000011), JALR (1100111)
  - 2: STORE (0100011)
  - 3: BRANCH (1100011)
  - 4: LUI (0110111), AUIPC (0010111)
  - 5: JAL (1101111)
- Unrecognised opcode: illegal=1, extOp=0; fields still sliced.
- Decode is combinational on in_instr; decoded fields are stored per entry together with pc.
- Push occurs when in_valid && in_ready && !flush.
- Pop occurs when out_valid && out_ready && !flush.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1.
- in_ready depends only on registered count; no combinational in-to-out path.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0; fetch holds in_pc/in_instr stable.
- Empty: out_valid=0; all decoded outputs and out_pc driven to 0.
- Order is strictly FIFO.
- Flush: next cycle count=0, pointers=0, out_valid=0, in_ready=1. Flush wins over a same-cycle push (instruction dropped) and same-cycle pop (no pop counted).
- Reset (rstn low, asynchronous, any time including mid-transfer): count=0, pointers=0, storage cleared, out_valid=0, in_ready=1, all data outputs 0.

Optional Feature:
- Macro: DECBUF_BYPASS_EN.
- Defined: when empty and in_valid && out_ready && !flush, the incoming instruction is driven combinationally to the outputs with out_valid=1 in the same cycle and is not stored (zero latency). in_ready remains !full.
- Undefined: minimum latency is one cycle, as above.

Test Plan:
- Reset asserted mid-run with 2 entries queued -> immediately out_valid=0, in_ready=1, extOp=0, immTypeI=0; after release, empty.
- Push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, extOp=1, immTypeI=12'hFFF, out_rd=1, out_rs1=0, illegal=0; pop empties.
- Push 0x0021A423 (sw x2,8(x3)) then 0xFE000EE3 (beq x0,x0,-4) -> extOp=2, immTypeS=12'h008, rs1=3, rs2=2; then extOp=3, immTypeB=13'h1FFC.
- Push 0x123450B7 (lui x1,0x12345), 0x008000EF (jal x1,+8), 0x0000007F -> extOp=4, immTypeU=20'h12345; extOp=5, immTypeJ=20'h00004; illegal=1, extOp=0.
- DEPTH=2, out_ready=0, three pushes -> in_ready=0 after second, third held; release out_ready -> pc order A,B,C preserved; simultaneous push/pop keeps count.
- Two entries queued, flush with in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1; flushed instruction never appears.
